// File: rtl/controle_cronometro_if.sv
// Control/display bundle of the countdown stopwatch: buttons and preset in, BCD digits and status out.
interface controle_cronometro_if;
   logic       btnIniciaPausa;
   logic       btnCarrega;
   logic       btnZera;
   logic [7:0] presetMinuto;
   logic [7:0] presetSegundo;
   logic [3:0] dezenaMinuto;
   logic [3:0] unidadeMinuto;
   logic [3:0] dezenaSegundos;
   logic [3:0] unidadeSegundos;
   logic [1:0] estado;
   logic       umSegundo;
   logic       alarme;

   modport master (
      output btnIniciaPausa, btnCarrega, btnZera, presetMinuto, presetSegundo,
      input  dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos, estado, umSegundo,
             alarme
   );

   modport slave (
      input  btnIniciaPausa, btnCarrega, btnZera, presetMinuto, presetSegundo,
      output dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos, estado, umSegundo,
             alarme
   );
endinterface

// File: rtl/controle_cronometro.sv
// Countdown stopwatch sequencer: button conditioning, one-second prescaler and MM:SS BCD digits.
module controle_cronometro #(
   parameter int unsigned TICKS_PER_SECOND = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES  = 500000
) (
   input logic                 clock,
   input logic                 resetN,
   controle_cronometro_if.slave bus
);

   localparam int unsigned PreW  = $clog2(TICKS_PER_SECOND);
   localparam int unsigned LockW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PreW-1:0]  PreMax   = PreW'(TICKS_PER_SECOND - 1);
   localparam logic [LockW-1:0] LockLoad = LockW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      StParado   = 2'd0,
      StContando = 2'd1,
      StPausado  = 2'd2,
      StFim      = 2'd3
   } estado_e;

   // Bit order: 0 iniciaPausa, 1 carrega, 2 zera.
   logic [2:0]       btnRaw, sync1Q, sync2Q, prevQ, eventoQ, aceita;
   logic [LockW-1:0] lockQ [3];

   assign btnRaw = {bus.btnZera, bus.btnCarrega, bus.btnIniciaPausa};

   always_comb begin
      aceita = '0;
      for (int b = 0; b < 3; b++) begin
         aceita[b] = sync2Q[b] & ~prevQ[b] & (lockQ[b] == '0);
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         sync1Q  <= '0;
         sync2Q  <= '0;
         prevQ   <= '0;
         eventoQ <= '0;
         for (int b = 0; b < 3; b++) lockQ[b] <= '0;
      end else begin
         sync1Q  <= btnRaw;
         sync2Q  <= sync1Q;
         prevQ   <= sync2Q;
         eventoQ <= aceita;
         for (int b = 0; b < 3; b++) begin
            if (aceita[b])              lockQ[b] <= LockLoad;
            else if (lockQ[b] != '0)    lockQ[b] <= lockQ[b] - 1'b1;
         end
      end
   end

   logic evZera, evCarrega, evInicia;
   assign evZera    = eventoQ[2];
   assign evCarrega = eventoQ[1] & ~eventoQ[2];
   assign evInicia  = eventoQ[0] & ~eventoQ[1] & ~eventoQ[2];

   estado_e         estadoQ;
   logic [PreW-1:0] preQ;
   logic [3:0]      dmQ, umQ, dsQ, usQ;
   logic            umSegundoQ, alarmeQ;

   function automatic logic [3:0] limita(input logic [3:0] v, input logic [3:0] maximo);
      return (v > maximo) ? maximo : v;
   endfunction

   logic [3:0] dmDec, umDec, dsDec, usDec;
   logic       tick, digitosZero, zeroApos;

   // Borrow chain for one-second decrement.
   always_comb begin
      usDec = (usQ == 4'd0) ? 4'd9 : usQ - 4'd1;
      dsDec = dsQ;
      umDec = umQ;
      dmDec = dmQ;
      if (usQ == 4'd0) begin
         dsDec = (dsQ == 4'd0) ? 4'd5 : dsQ - 4'd1;
         if (dsQ == 4'd0) begin
            umDec = (umQ == 4'd0) ? 4'd9 : umQ - 4'd1;
            if (umQ == 4'd0) dmDec = dmQ - 4'd1;
         end
      end
      tick        = (estadoQ == StContando) && (preQ == PreMax);
      digitosZero = {dmQ, umQ, dsQ, usQ} == 16'h0000;
      zeroApos    = {dmDec, umDec, dsDec, usDec} == 16'h0000;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         estadoQ    <= StParado;
         preQ       <= '0;
         {dmQ, umQ, dsQ, usQ} <= '0;
         umSegundoQ <= 1'b0;
         alarmeQ    <= 1'b0;
      end else begin
         umSegundoQ <= tick & ~evZera;
         // Alarm trails FIM by one cycle but drops together with the leaving event.
         alarmeQ    <= (estadoQ == StFim) & ~evZera & ~evCarrega;
         if (evZera) begin
            estadoQ <= StParado;
            preQ    <= '0;
            {dmQ, umQ, dsQ, usQ} <= '0;
         end else begin
            unique case (estadoQ)
               StParado: begin
                  if (evCarrega) begin
                     dmQ <= limita(bus.presetMinuto[7:4], 4'd5);
                     umQ <= limita(bus.presetMinuto[3:0], 4'd9);
                     dsQ <= limita(bus.presetSegundo[7:4], 4'd5);
                     usQ <= limita(bus.presetSegundo[3:0], 4'd9);
                  end else if (evInicia && !digitosZero) begin
                     estadoQ <= StContando;
                     preQ    <= '0;
                  end
               end
               StContando: begin
                  if (tick) begin
                     preQ <= '0;
                     {dmQ, umQ, dsQ, usQ} <= {dmDec, umDec, dsDec, usDec};
                     if (zeroApos)      estadoQ <= StFim;
                     else if (evInicia) estadoQ <= StPausado;
                  end else begin
                     preQ <= preQ + 1'b1;
                     if (evInicia) estadoQ <= StPausado;
                  end
               end
               StPausado, StFim: begin
                  if (evInicia && estadoQ == StPausado) begin
                     estadoQ <= StContando;
                  end else if (evCarrega) begin
                     estadoQ <= StParado;
                     dmQ <= limita(bus.presetMinuto[7:4], 4'd5);
                     umQ <= limita(bus.presetMinuto[3:0], 4'd9);
                     dsQ <= limita(bus.presetSegundo[7:4], 4'd5);
                     usQ <= limita(bus.presetSegundo[3:0], 4'd9);
                  end
               end
            endcase
         end
      end
   end

   assign bus.dezenaMinuto    = dmQ;
   assign bus.unidadeMinuto   = umQ;
   assign bus.dezenaSegundos  = dsQ;
   assign bus.unidadeSegundos = usQ;
   assign bus.estado          = estadoQ;
   assign bus.umSegundo       = umSegundoQ;
   assign bus.alarme          = alarmeQ;

endmodule

// File: tb/tb_controle_cronometro.sv
// Bench for controle_cronometro: seconds-level reference model, tick scoreboard, directed + random.
module tb_controle_cronometro;
   localparam int T = 4;
   localparam int D = 2;

   logic clock  = 1'b0;
   logic resetN = 1'b1;
   controle_cronometro_if bus();

   controle_cronometro #(.TICKS_PER_SECOND(T), .DEBOUNCE_CYCLES(D)) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int nVec = 0, nErr = 0, tickCount = 0;
   bit checkEn = 1'b0;

   // Model: time held as plain seconds; states 0 PARADO, 1 CONTANDO, 2 PAUSADO, 3 FIM.
   int mSecs, mState, mPre, mLock[3];
   bit mUm, mAlarm;
   bit mEvt[3], h1[3], h2[3], h3[3];

   typedef struct {logic [15:0] dig; logic [1:0] est;} exp_t;
   exp_t expQ[$];

   function automatic logic [15:0] bcdOf(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int loadSecs();
      int mt, mu, st, su;
      mt = int'(bus.presetMinuto[7:4]);  mu = int'(bus.presetMinuto[3:0]);
      st = int'(bus.presetSegundo[7:4]); su = int'(bus.presetSegundo[3:0]);
      if (mt > 5) mt = 5;
      if (mu > 9) mu = 9;
      if (st > 5) st = 5;
      if (su > 9) su = 9;
      return (mt * 10 + mu) * 60 + st * 10 + su;
   endfunction

   task automatic modelReset();
      mSecs = 0; mState = 0; mPre = 0; mUm = 0; mAlarm = 0;
      for (int b = 0; b < 3; b++) begin
         mLock[b] = 0; mEvt[b] = 0; h1[b] = 0; h2[b] = 0; h3[b] = 0;
      end
      expQ.delete();
   endtask

   task automatic modelStep();
      bit raw[3];
      bit z, c, i, tick, acc;
      exp_t e;
      raw[0] = bus.btnIniciaPausa; raw[1] = bus.btnCarrega; raw[2] = bus.btnZera;
      z = mEvt[2];
      c = mEvt[1] && !z;
      i = mEvt[0] && !z && !c;
      tick   = (mState == 1) && (mPre == T - 1);
      mAlarm = (mState == 3) && !z && !c;
      mUm    = tick && !z;
      if (z) begin
         mSecs = 0; mState = 0; mPre = 0;
      end else begin
         case (mState)
            0: if (c) mSecs = loadSecs();
               else if (i && mSecs != 0) begin mState = 1; mPre = 0; end
            1: if (tick) begin
                  mSecs--; mPre = 0;
                  if (mSecs == 0) mState = 3;
                  else if (i) mState = 2;
               end else begin
                  mPre++;
                  if (i) mState = 2;
               end
            2: if (i) mState = 1;
               else if (c) begin mSecs = loadSecs(); mState = 0; end
            3: if (c) begin mSecs = loadSecs(); mState = 0; end
            default: ;
         endcase
      end
      if (mUm) begin
         e.dig = bcdOf(mSecs);
         e.est = 2'(mState);
         expQ.push_back(e);
      end
      // An edge is seen by the controller two samples after the pin rises.
      for (int b = 0; b < 3; b++) begin
         acc = h2[b] && !h3[b] && (mLock[b] == 0);
         mLock[b] = acc ? D : (mLock[b] > 0 ? mLock[b] - 1 : 0);
         mEvt[b] = acc;
         h3[b] = h2[b]; h2[b] = h1[b]; h1[b] = raw[b];
      end
   endtask

   initial forever begin
      @(posedge clock);
      if (resetN) modelStep();
   end

   task automatic cmp(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dutDig();
      return {bus.dezenaMinuto, bus.unidadeMinuto, bus.dezenaSegundos, bus.unidadeSegundos};
   endfunction

   always @(negedge clock) begin
      if (checkEn) begin
         cmp("estado", int'(bus.estado), mState);
         cmp("alarme", int'(bus.alarme), int'(mAlarm));
         cmp("digitos", int'(dutDig()), int'(bcdOf(mSecs)));
         if (bus.umSegundo) begin
            tickCount++;
            if (expQ.size() == 0) begin
               cmp("tick_espurio", 1, 0);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               cmp("tick_digitos", int'(dutDig()), int'(e.dig));
               cmp("tick_estado", int'(bus.estado), int'(e.est));
            end
         end else if (expQ.size() != 0) begin
            void'(expQ.pop_front());
            cmp("tick_ausente", 0, 1);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic setBtn(input int b, input bit v);
      case (b)
         0:       bus.btnIniciaPausa = v;
         1:       bus.btnCarrega     = v;
         default: bus.btnZera        = v;
      endcase
   endtask

   task automatic press(input int b, input int hold);
      setBtn(b, 1'b1);
      step(hold);
      setBtn(b, 1'b0);
   endtask

   task automatic loadPreset(input logic [7:0] mm, input logic [7:0] ss);
      bus.presetMinuto  = mm;
      bus.presetSegundo = ss;
      press(1, 2);
      step(6);
   endtask

   int base;

   initial begin
      bus.btnIniciaPausa = 0; bus.btnCarrega = 0; bus.btnZera = 0;
      bus.presetMinuto = 8'h00; bus.presetSegundo = 8'h00;
      modelReset();
      #1 resetN = 1'b0;
      #1;
      cmp("reset_digitos", int'(dutDig()), 0);
      cmp("reset_estado", int'(bus.estado), 0);
      cmp("reset_alarme", int'(bus.alarme), 0);
      cmp("reset_umSegundo", int'(bus.umSegundo), 0);
      repeat (2) @(posedge clock);
      #1 resetN = 1'b1;
      checkEn = 1'b1;

      // Load 01:02 and count three seconds.
      loadPreset(8'h01, 8'h02);
      cmp("carga_0102", int'(dutDig()), 16'h0102);
      base = tickCount;
      press(0, 2);
      step(15);
      cmp("conta_pulsos", tickCount - base, 3);
      cmp("conta_0059", int'(dutDig()), 16'h0059);
      press(2, 2);
      step(6);

      // Expiry from 00:02.
      loadPreset(8'h00, 8'h02);
      press(0, 2);
      step(12);
      cmp("fim_estado", int'(bus.estado), 3);
      cmp("fim_alarme", int'(bus.alarme), 1);
      cmp("fim_digitos", int'(dutDig()), 0);
      press(0, 2);
      step(6);
      cmp("fim_ignora_inicia", int'(bus.estado), 3);
      press(1, 2);
      step(6);
      cmp("fim_carrega_estado", int'(bus.estado), 0);
      cmp("fim_carrega_alarme", int'(bus.alarme), 0);
      cmp("fim_carrega_digitos", int'(dutDig()), 16'h0002);

      // Pause two cycles into a second, hold, resume.
      loadPreset(8'h01, 8'h00);
      press(0, 2);
      step(4);
      press(0, 2);
      step(22);
      base = tickCount;
      cmp("pausa_estado", int'(bus.estado), 2);
      cmp("pausa_digitos", int'(dutDig()), 16'h0059);
      step(20);
      cmp("pausa_sem_tick", tickCount - base, 0);
      cmp("pausa_congelado", int'(dutDig()), 16'h0059);
      press(0, 2);
      step(3);
      cmp("retoma_antes", int'(dutDig()), 16'h0059);
      step(1);
      cmp("retoma_tick", int'(dutDig()), 16'h0058);
      press(2, 2);
      step(6);

      // Bounce inside the lockout gives a single toggle.
      loadPreset(8'h00, 8'h30);
      setBtn(0, 1'b1); step(1);
      setBtn(0, 1'b0); step(1);
      setBtn(0, 1'b1); step(5);
      setBtn(0, 1'b0); step(6);
      cmp("debounce_estado", int'(bus.estado), 1);
      setBtn(2, 1'b1); setBtn(1, 1'b1);
      step(2);
      setBtn(2, 1'b0); setBtn(1, 1'b0);
      step(6);
      cmp("prioridade_estado", int'(bus.estado), 0);
      cmp("prioridade_digitos", int'(dutDig()), 0);

      // Preset sanitising and zero start.
      loadPreset(8'hA7, 8'h6F);
      cmp("saneia_a7_6f", int'(dutDig()), 16'h5759);
      loadPreset(8'h7C, 8'h7C);
      cmp("saneia_7c_7c", int'(dutDig()), 16'h5959);
      press(2, 2);
      step(6);
      press(0, 2);
      step(6);
      cmp("zero_inicia", int'(bus.estado), 0);

      // Asynchronous reset mid-count.
      loadPreset(8'h00, 8'h30);
      press(0, 2);
      step(10);
      #1 resetN = 1'b0;
      modelReset();
      #1;
      cmp("reset_async_digitos", int'(dutDig()), 0);
      cmp("reset_async_estado", int'(bus.estado), 0);
      cmp("reset_async_alarme", int'(bus.alarme), 0);
      @(posedge clock);
      #1 resetN = 1'b1;

      // Random buttons and presets against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0)  bus.btnIniciaPausa = ~bus.btnIniciaPausa;
         if ($urandom_range(0, 39) == 0) bus.btnCarrega = ~bus.btnCarrega;
         if ($urandom_range(0, 299) == 0)    bus.btnZera = 1'b1;
         else if ($urandom_range(0, 3) == 0) bus.btnZera = 1'b0;
         if ($urandom_range(0, 49) == 0) begin
            bus.presetMinuto  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bus.presetSegundo = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                             : 8'($urandom_range(0, 9));
         end
         step(1);
      end
      bus.btnIniciaPausa = 0; bus.btnCarrega = 0; bus.btnZera = 0;
      step(10);
      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
